// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry {pc, data} FIFO with registered head outputs and synchronous flush.
module fetch_fifo2 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [31:0]       push_pc,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [31:0]       head_pc,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [31:0]       head_pc_q, tail_pc_q;
  logic [DATA_W-1:0] head_data_q, tail_data_q;
  logic [1:0]        count_q;

  // Flush wins over push/pop: a handshake in the flush cycle is still consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_pc_q   <= '0;
      head_data_q <= '0;
      tail_pc_q   <= '0;
      tail_data_q <= '0;
      count_q     <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_q   <= push_pc;
            head_data_q <= push_data;
          end else begin
            tail_pc_q   <= push_pc;
            tail_data_q <= push_data;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_pc_q   <= tail_pc_q;
          head_data_q <= tail_data_q;
          count_q     <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_pc_q   <= push_pc;
            head_data_q <= push_data;
          end else begin
            head_pc_q   <= tail_pc_q;
            head_data_q <= tail_data_q;
            tail_pc_q   <= push_pc;
            tail_data_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid     = (count_q != 2'd0);
  assign head_pc   = head_pc_q;
  assign head_data = head_data_q;
  assign count     = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: PC, ROM read issue, 2-entry buffer, redirect and halt.
// Define FETCH_BOUND_CHECK_EN to stop on fetches beyond DEPTH and expose a sticky fetch_err.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 2048,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       rom_addra,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [31:0]       instr_pc,
  output logic              busy
`ifdef FETCH_BOUND_CHECK_EN
  , output logic            fetch_err
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, inflight_pc_q;
  logic         inflight_q;
  logic [1:0]   fifo_count;
  logic [2:0]   occupancy;
  logic         pop, kill, push, can_issue, in_bounds;
  logic         unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pop  = instr_valid & instr_ready;
  assign kill = redirect_valid & (state_q != StIdle);
  assign push = inflight_q & ~kill;

  // Slots still committed after this cycle's handshake; ROM latency caps inflight at one.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign can_issue = (state_q == StRun) & ~redirect_valid & ~halt & (occupancy < 3'd2);

`ifdef FETCH_BOUND_CHECK_EN
  logic fetch_err_q;
  logic bound_err;

  assign in_bounds = ({2'b00, pc_q[31:2]} < DEPTH);
  assign bound_err = can_issue & ~in_bounds;
  assign fetch_err = fetch_err_q;
`else
  // Without the check the ROM simply aliases out-of-range word addresses.
  logic unused_depth;

  assign unused_depth = (DEPTH == 0);
  assign in_bounds    = 1'b1;
`endif

  assign rom_en    = can_issue & in_bounds;
  assign rom_addra = rom_en ? {2'b00, pc_q[31:2]} : 32'd0;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
`ifdef FETCH_BOUND_CHECK_EN
      fetch_err_q   <= 1'b0;
`endif
    end else begin
      inflight_q <= rom_en;
      if (rom_en) inflight_pc_q <= pc_q;

      if (kill) begin
        pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (rom_en) begin
        pc_q <= pc_q + PC_INC;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
`ifdef FETCH_BOUND_CHECK_EN
            fetch_err_q <= 1'b0;
`endif
          end
        end
        StRun: begin
`ifdef FETCH_BOUND_CHECK_EN
          if (bound_err) fetch_err_q <= 1'b1;
          if (halt || bound_err) state_q <= StDrain;
`else
          if (halt) state_q <= StDrain;
`endif
        end
        StDrain: begin
          if ((fifo_count == 2'd0) && !inflight_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fetch_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (kill),
    .push      (push),
    .push_pc   (inflight_pc_q),
    .push_data (rom_dout),
    .pop       (pop),
    .valid     (instr_valid),
    .head_pc   (instr_pc),
    .head_data (instr_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed per-cycle vectors plus an in-order word queue.
module tb_instr_fetch_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              rst, start, halt, redirect_valid, instr_ready;
  logic [31:0]       redirect_pc, rom_addra, instr_pc;
  logic              rom_en, instr_valid, busy;
  logic [DATA_W-1:0] rom_dout = '0;
  logic [DATA_W-1:0] instr_data;
`ifdef FETCH_BOUND_CHECK_EN
  logic              fetch_err;
`endif

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  typedef struct {
    logic        rdy, hlt, rv;
    logic [31:0] rpc;
    logic        en;
    logic [31:0] addr;
    logic        vld, bsy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addra      (rom_addra),
    .rom_en         (rom_en),
    .rom_dout       (rom_dout),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .busy           (busy)
`ifdef FETCH_BOUND_CHECK_EN
    , .fetch_err    (fetch_err)
`endif
  );

  // ROM[i] = i, one cycle read latency, word address aliased onto DEPTH entries.
  always @(posedge clk) begin
    if (rom_en) rom_dout <= DATA_W'(rom_addra % DEPTH);
  end

  // Monitor: every accepted instruction must be the next expected {pc, data}.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_instr: got pc %h data %h, expected no instruction",
                 instr_pc, instr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({instr_pc, instr_data} !== mon_exp) begin
          fails++;
          $display("FAIL instr_stream: got pc %h data %h, expected pc %h data %h",
                   instr_pc, instr_data, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
    exp_q.push_back({pc, data});
  endtask

  function automatic vec_t v(input logic rdy, input logic hlt, input logic rv,
                             input logic [31:0] rpc, input logic en, input logic [31:0] addr,
                             input logic vld, input logic bsy);
    vec_t t;
    t.rdy  = rdy;
    t.hlt  = hlt;
    t.rv   = rv;
    t.rpc  = rpc;
    t.en   = en;
    t.addr = addr;
    t.vld  = vld;
    t.bsy  = bsy;
    return t;
  endfunction

  // Pulse start in the current (idle) cycle, then apply one vector per cycle after the edge.
  task automatic run_phase(input string name);
    start = 1'b1;
    foreach (vecs[i]) begin
      step();
      start          = 1'b0;
      instr_ready    = vecs[i].rdy;
      halt           = vecs[i].hlt;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      chk($sformatf("%s[%0d].rom_en", name, i), 32'(rom_en), 32'(vecs[i].en));
      chk($sformatf("%s[%0d].rom_addra", name, i), rom_addra, vecs[i].addr);
      chk($sformatf("%s[%0d].instr_valid", name, i), 32'(instr_valid), 32'(vecs[i].vld));
      chk($sformatf("%s[%0d].busy", name, i), 32'(busy), 32'(vecs[i].bsy));
    end
    vecs.delete();
    halt           = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".rom_en"}, 32'(rom_en), 32'd0);
    chk({name, ".rom_addra"}, rom_addra, 32'd0);
    chk({name, ".instr_valid"}, 32'(instr_valid), 32'd0);
    chk({name, ".instr_data"}, instr_data, 32'd0);
    chk({name, ".instr_pc"}, instr_pc, 32'd0);
    chk({name, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    step();
    step();
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Stream with ready high, then halt: everything issued is delivered, busy falls.
    for (int k = 0; k < 8; k++) push_exp(32'(4 * k), 32'(k));
    for (int c = 0; c < 8; c++) vecs.push_back(v(1, 0, 0, 0, 1, 32'(c), c >= 2, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
    run_phase("stream_halt");

    // Restart at RESET_PC; ready low for 5 cycles stalls issue at 2 outstanding.
    for (int k = 0; k < 7; k++) push_exp(32'(4 * k), 32'(k));
    for (int c = 0; c < 4; c++) vecs.push_back(v(1, 0, 0, 0, 1, 32'(c), c >= 2, 1));
    for (int c = 4; c < 9; c++) vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1));
    for (int c = 9; c < 12; c++) vecs.push_back(v(1, 0, 0, 0, 1, 32'(c - 5), 1, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
    run_phase("stall");

    // Redirect flushing a buffered word and killing an inflight one, then a redirect
    // coinciding with a handshake (pc 0x48 consumed exactly once).
    push_exp(32'h40, 32'd16);
    push_exp(32'h44, 32'd17);
    push_exp(32'h48, 32'd18);
    push_exp(32'h100, 32'd64);
    push_exp(32'h104, 32'd65);
    push_exp(32'h108, 32'd66);
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 1, 32'h43, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 16, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 17, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 18, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 19, 1, 1));
    vecs.push_back(v(1, 0, 1, 32'h100, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 64, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 65, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 66, 1, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
    run_phase("redirect");

    // Redirect and halt together: flush, drain, target never fetched.
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(v(0, 1, 1, 32'h80, 0, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    run_phase("redirect_halt");

`ifdef FETCH_BOUND_CHECK_EN
    // Last in-range word is delivered, the next fetch is refused and sets fetch_err.
    push_exp(32'h1FFC, 32'd2047);
    vecs.push_back(v(1, 0, 1, 32'h1FFC, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 32'd2047, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
    run_phase("bound");
    chk("bound.fetch_err_set", 32'(fetch_err), 32'd1);
`else
    // PC wraps from 0xFFFFFFFC to 0; the ROM aliases the top word address.
    push_exp(32'hFFFF_FFFC, 32'd2047);
    push_exp(32'h0, 32'd0);
    push_exp(32'h4, 32'd1);
    vecs.push_back(v(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 32'h3FFF_FFFF, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
    run_phase("wrap");
`endif

    // Reset mid-operation: outputs return to zero and the inflight read is dropped.
    start = 1'b1;
    step();
    start = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("midrst.first_issue", 32'(rom_en), 32'd1);
`ifdef FETCH_BOUND_CHECK_EN
    chk("midrst.fetch_err_cleared", 32'(fetch_err), 32'd0);
`endif
    step();
    rst = 1'b1;
    step();
    #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    step();
    step();
    #1;
    chk("midrst.no_valid", 32'(instr_valid), 32'd0);
    chk("midrst.idle", 32'(busy), 32'd0);

    step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
